// File: rtl/task_answer_arbiter_pkg.sv
// rtl/task_answer_arbiter_pkg.sv - shared types and helpers for the task answer arbiter
package task_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_STREAM,
        S_RELEASE
    } arb_state_e;

    // Index width that stays at least one bit wide for tiny task counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/task_answer_arbiter_if.sv
// rtl/task_answer_arbiter_if.sv - task-side and manager-side answer channel bundle
interface task_answer_arbiter_if #(
    parameter int NUM_TASKS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SIZE_WIDTH = 12
);
    import task_arb_pkg::*;

    localparam int ID_W = clog2_min1(NUM_TASKS);

    logic [NUM_TASKS-1:0]            i_tanswer_ready;
    logic [NUM_TASKS*DATA_WIDTH-1:0] i_tdata;
    logic [NUM_TASKS-1:0]            i_tanswer_data_last;
    logic [NUM_TASKS*SIZE_WIDTH-1:0] i_packet_size_in_bytes;
    logic [NUM_TASKS-1:0]            o_tmanager_ready;
    logic                            i_tmanager_ready;
    logic                            o_tanswer_ready;
    logic [DATA_WIDTH-1:0]           o_tdata;
    logic                            o_tanswer_data_last;
    logic [SIZE_WIDTH-1:0]           o_packet_size_in_bytes;
    logic [ID_W-1:0]                 o_task_id;

    modport master (
        input  i_tanswer_ready, i_tdata, i_tanswer_data_last, i_packet_size_in_bytes,
        input  i_tmanager_ready,
        output o_tmanager_ready, o_tanswer_ready, o_tdata, o_tanswer_data_last,
        output o_packet_size_in_bytes, o_task_id
    );

    modport slave (
        output i_tanswer_ready, i_tdata, i_tanswer_data_last, i_packet_size_in_bytes,
        output i_tmanager_ready,
        input  o_tmanager_ready, o_tanswer_ready, o_tdata, o_tanswer_data_last,
        input  o_packet_size_in_bytes, o_task_id
    );

endinterface

// File: rtl/task_answer_arbiter_picker.sv
// rtl/task_answer_arbiter_picker.sv - combinational round-robin requester picker
module rr_priority_picker
    import task_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest slot to the nearest so the first requester after ptr wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/task_answer_arbiter.sv
// rtl/task_answer_arbiter.sv - round-robin owner of the task manager answer channel
module task_answer_arbiter
    import task_arb_pkg::*;
#(
    parameter int NUM_TASKS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SIZE_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    task_answer_arbiter_if.master bus,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_size_error
);

    localparam int ID_W = clog2_min1(NUM_TASKS);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, task_id_q, pick_idx;
    logic                  pick_valid;
    logic [SIZE_WIDTH-1:0] size_q, beat_cnt_q, beat_next;
    logic [WD_W-1:0]       wd_q;
    logic                  timeout_q, size_error_q;
    logic                  stream_live, last_g, strobe, wd_expired;
    logic [DATA_WIDTH-1:0] tdata_arr [NUM_TASKS];
    logic [SIZE_WIDTH-1:0] size_arr  [NUM_TASKS];

    for (genvar k = 0; k < NUM_TASKS; k++) begin : g_unpack
        assign tdata_arr[k] = bus.i_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign size_arr[k]  = bus.i_packet_size_in_bytes[k*SIZE_WIDTH +: SIZE_WIDTH];
    end

    rr_priority_picker #(
        .N    (NUM_TASKS),
        .ID_W (ID_W)
    ) u_picker (
        .req   (bus.i_tanswer_ready),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Reset gates the stream path immediately so the owner sees its strobe drop in the reset cycle.
    assign stream_live = (state_q == S_STREAM) && !i_rst;
    assign last_g      = bus.i_tanswer_data_last[task_id_q];
    assign strobe      = stream_live && bus.i_tmanager_ready;
    assign wd_expired  = (wd_q == WD_LAST);
    // Beats read including the current strobe, so a last beat read with last counts.
    assign beat_next   = (strobe && (beat_cnt_q != '1)) ? beat_cnt_q + SIZE_WIDTH'(1) : beat_cnt_q;

    assign bus.o_task_id              = task_id_q;
    assign bus.o_packet_size_in_bytes = size_q;
    assign o_timeout                  = timeout_q;
    assign o_size_error               = size_error_q;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one packet per grant, released by last (preferred) or the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pick_valid) state_d = S_GRANT;
            S_GRANT:   state_d = S_STREAM;
            S_STREAM:  if (last_g || wd_expired) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Channel outputs: only the owner is muxed through, and only while streaming.
    always_comb begin
        bus.o_tanswer_ready     = (state_q == S_GRANT) || (state_q == S_STREAM);
        o_busy                  = (state_q != S_IDLE);
        bus.o_tdata             = stream_live ? tdata_arr[task_id_q] : '0;
        bus.o_tanswer_data_last = stream_live && last_g;
        bus.o_tmanager_ready    = '0;
        for (int k = 0; k < NUM_TASKS; k++) begin
            if (strobe && (task_id_q == ID_W'(k))) begin
                bus.o_tmanager_ready[k] = 1'b1;
            end
        end
    end

    // Grant/size latches, beat counter, watchdog, rr pointer and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q        <= ID_W'(NUM_TASKS - 1);
            task_id_q    <= '0;
            size_q       <= '0;
            beat_cnt_q   <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            size_error_q <= 1'b0;
        end else begin
            timeout_q    <= 1'b0;
            size_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        task_id_q <= pick_idx;
                        size_q    <= size_arr[pick_idx];
                    end
                end
                S_GRANT: begin
                    beat_cnt_q <= '0;
                    wd_q       <= '0;
                end
                S_STREAM: begin
                    beat_cnt_q <= beat_next;
                    if (last_g) begin
                        size_error_q <= (beat_next != size_q);
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_RELEASE: begin
                    ptr_q      <= task_id_q;
                    beat_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_task_answer_arbiter.sv
// tb/tb_task_answer_arbiter.sv - self-checking bench for task_answer_arbiter
module tb_task_answer_arbiter;
    import task_arb_pkg::*;

    localparam int NT  = 4;
    localparam int DW  = 8;
    localparam int SW  = 12;
    localparam int TO  = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic o_busy, o_timeout, o_size_error;

    int n_vec = 0;
    int n_err = 0;

    task_answer_arbiter_if #(.NUM_TASKS(NT), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

    task_answer_arbiter #(
        .NUM_TASKS      (NT),
        .DATA_WIDTH     (DW),
        .SIZE_WIDTH     (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_size_error (o_size_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the channel, how long since the grant, what was read.
    int          m_owner   = -1;
    int          m_since   = 0;
    int          m_cool    = 0;
    int          m_ptr     = NT - 1;
    int          m_reads   = 0;
    int          m_task_id = 0;
    int          m_size    = 0;
    bit          m_to      = 0;
    bit          m_se      = 0;
    bit          e_stream, e_last, found;
    logic [DW-1:0] e_data;
    logic [NT-1:0] e_tmr;
    int          pick;

    always @(negedge i_clk) begin
        if (i_rst) begin
            check("rst_tmgr_ready", bus.o_tmanager_ready, '0);
            m_owner = -1; m_since = 0; m_cool = 0; m_ptr = NT - 1; m_reads = 0;
            m_task_id = 0; m_size = 0; m_to = 0; m_se = 0;
        end else begin
            e_stream = (m_owner >= 0) && (m_since >= 1);
            e_last   = e_stream && (((bus.i_tanswer_data_last >> m_owner) & 1) != 0);
            e_data   = e_stream ? DW'(bus.i_tdata >> (m_owner * DW)) : '0;
            e_tmr    = (e_stream && bus.i_tmanager_ready) ? NT'(1 << m_owner) : '0;
            check("m_tanswer_ready", bus.o_tanswer_ready, m_owner >= 0);
            check("m_busy", o_busy, (m_owner >= 0) || (m_cool > 0));
            check("m_tdata", bus.o_tdata, e_data);
            check("m_last", bus.o_tanswer_data_last, e_last);
            check("m_tmgr_ready", bus.o_tmanager_ready, e_tmr);
            check("m_task_id", bus.o_task_id, m_task_id);
            check("m_size", bus.o_packet_size_in_bytes, m_size);
            check("m_timeout", o_timeout, m_to);
            check("m_size_error", o_size_error, m_se);
            m_to = 0;
            m_se = 0;
            if (m_owner >= 0) begin
                if (m_since == 0) begin
                    m_since = 1;
                    m_reads = 0;
                end else begin
                    if (bus.i_tmanager_ready && m_reads < 4095) m_reads++;
                    if (e_last) begin
                        m_se = (m_reads != m_size);
                        m_ptr = m_owner; m_owner = -1; m_cool = 1;
                    end else if (m_since == TO) begin
                        m_to = 1;
                        m_ptr = m_owner; m_owner = -1; m_cool = 1;
                    end else begin
                        m_since++;
                    end
                end
            end else if (m_cool > 0) begin
                m_cool = 0;
            end else if (bus.i_tanswer_ready != '0) begin
                found = 0;
                pick  = 0;
                for (int d = 1; d <= NT; d++) begin
                    if (!found && (((bus.i_tanswer_ready >> ((m_ptr + d) % NT)) & 1) != 0)) begin
                        found = 1;
                        pick  = (m_ptr + d) % NT;
                    end
                end
                m_owner   = pick;
                m_since   = 0;
                m_task_id = pick;
                m_size    = int'(SW'(bus.i_packet_size_in_bytes >> (pick * SW)));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_tanswer_ready     = '0;
        bus.i_tanswer_data_last = '0;
        bus.i_tmanager_ready    = 1'b0;
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        idle_inputs();
        repeat (n) tick();
        i_rst = 1'b0;
    endtask

    task automatic drain();
        bus.i_tanswer_ready     = '0;
        bus.i_tanswer_data_last = '1;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (!o_busy) break;
            tick();
        end
        check("drain_idle", o_busy, 1'b0);
        tick();
        idle_inputs();
    endtask

    task automatic send(input int t, input int sz, input int nb, output logic se);
        int nbeat;
        logic [NT-1:0] oh;
        nbeat = (nb < 1) ? 1 : nb;
        oh = NT'(1) << t;
        bus.i_tanswer_ready = oh;
        bus.i_packet_size_in_bytes[t*SW +: SW] = SW'(sz);
        @(negedge i_clk);
        check("req_cycle_ready", bus.o_tanswer_ready, 1'b0);
        tick();
        bus.i_tanswer_ready = '0;
        @(negedge i_clk);
        check("grant_ready", bus.o_tanswer_ready, 1'b1);
        check("grant_task_id", bus.o_task_id, t);
        check("grant_size", bus.o_packet_size_in_bytes, sz);
        check("grant_tmgr_ready", bus.o_tmanager_ready, '0);
        tick();
        for (int b = 0; b < nbeat; b++) begin
            bus.i_tmanager_ready    = (b < nb);
            bus.i_tanswer_data_last = (b == nbeat - 1) ? oh : '0;
            bus.i_tdata[t*DW +: DW] = DW'(8'h30 + b);
            @(negedge i_clk);
            check("stream_tmgr_ready", bus.o_tmanager_ready, (b < nb) ? oh : '0);
            check("stream_tdata", bus.o_tdata, 8'h30 + b);
            tick();
        end
        idle_inputs();
        @(negedge i_clk);
        se = o_size_error;
        check("release_ready", bus.o_tanswer_ready, 1'b0);
        check("release_busy", o_busy, 1'b1);
        check("release_timeout", o_timeout, 1'b0);
        tick();
        @(negedge i_clk);
        check("after_release_busy", o_busy, 1'b0);
        tick();
    endtask

    logic se;
    int   ids[4];
    int   gaps[4];
    int   exp_ids[4] = '{0, 1, 3, 0};
    int   ng, low, n;
    logic prev, got;

    initial begin
        bus.i_tdata = '0;
        bus.i_packet_size_in_bytes = '0;
        idle_inputs();
        do_reset(2);

        // Reset state.
        @(negedge i_clk);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", bus.o_tanswer_ready, 1'b0);
        check("rst_task_id", bus.o_task_id, 0);
        check("rst_size", bus.o_packet_size_in_bytes, 0);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_size_error", o_size_error, 1'b0);
        tick();

        // Single requester, size 1, one strobe.
        send(2, 1, 1, se);
        check("t1_no_size_error", se, 1'b0);

        // Short packet flags a size error, exact packet does not.
        send(1, 3, 2, se);
        check("t4_short_size_error", se, 1'b1);
        send(1, 3, 3, se);
        check("t4_exact_no_error", se, 1'b0);

        // Manager strobe toggling mirrored onto the owner only.
        bus.i_tanswer_ready = 4'b0100;
        @(negedge i_clk); tick();
        bus.i_tanswer_ready = '0;
        @(negedge i_clk); tick();
        for (int b = 0; b < 6; b++) begin
            bus.i_tmanager_ready    = (b % 2 == 0);
            bus.i_tanswer_data_last = (b == 5) ? 4'b0100 : 4'b0000;
            @(negedge i_clk);
            check("t6_tmgr_mirror", bus.o_tmanager_ready, (b % 2 == 0) ? 4'b0100 : 4'b0000);
            tick();
        end
        drain();

        // Watchdog: task 1 never asserts last.
        bus.i_tanswer_ready = 4'b0010;
        @(negedge i_clk); tick();
        bus.i_tanswer_ready   = '0;
        bus.i_tmanager_ready  = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge i_clk);
            if (o_timeout) begin
                got = 1'b1;
            end else begin
                n++;
                tick();
            end
        end
        check("t3_timeout_seen", got, 1'b1);
        check("t3_timeout_latency", n, TO + 1);
        check("t3_released_ready", bus.o_tanswer_ready, 1'b0);
        tick();
        idle_inputs();
        @(negedge i_clk);
        check("t3_idle_after", o_busy, 1'b0);
        check("t3_pulse_width", o_timeout, 1'b0);
        tick();

        // Round robin over tasks 0,1,3 after reset.
        do_reset(1);
        bus.i_tanswer_ready     = 4'b1011;
        bus.i_tanswer_data_last = 4'b1111;
        bus.i_tmanager_ready    = 1'b1;
        ng = 0; low = 0; prev = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge i_clk);
            if (bus.o_tanswer_ready && !prev) begin
                ids[ng]  = int'(bus.o_task_id);
                gaps[ng] = low;
                ng++;
            end
            low  = bus.o_tanswer_ready ? 0 : low + 1;
            prev = bus.o_tanswer_ready;
            tick();
        end
        check("t2_grant_count", ng, 4);
        for (int i = 0; i < ng; i++) begin
            check("t2_grant_order", ids[i], exp_ids[i]);
            if (i > 0) check("t2_gap", gaps[i], 2);
        end
        drain();

        // Reset in the middle of a stream.
        bus.i_tanswer_ready = 4'b1000;
        @(negedge i_clk); tick();
        bus.i_tanswer_ready = '0;
        @(negedge i_clk); tick();
        bus.i_tmanager_ready = 1'b1;
        @(negedge i_clk);
        check("t5_pre_rst_tmgr", bus.o_tmanager_ready, 4'b1000);
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        check("t5_rst_tmgr_drop", bus.o_tmanager_ready, 4'b0000);
        tick();
        i_rst = 1'b0;
        bus.i_tmanager_ready = 1'b0;
        @(negedge i_clk);
        check("t5_ready", bus.o_tanswer_ready, 1'b0);
        check("t5_busy", o_busy, 1'b0);
        check("t5_task_id", bus.o_task_id, 0);
        check("t5_size", bus.o_packet_size_in_bytes, 0);
        check("t5_timeout", o_timeout, 1'b0);
        check("t5_size_error", o_size_error, 1'b0);
        tick();
        bus.i_tanswer_ready = 4'b1111;
        @(negedge i_clk); tick();
        bus.i_tanswer_ready = '0;
        @(negedge i_clk);
        check("t5_first_grant", bus.o_task_id, 0);
        check("t5_first_ready", bus.o_tanswer_ready, 1'b1);
        tick();
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            i_rst                   = ($urandom_range(0, 299) == 0);
            bus.i_tanswer_ready     = NT'($urandom);
            bus.i_tdata             = (NT*DW)'($urandom);
            bus.i_tmanager_ready    = $urandom_range(0, 1) == 1;
            for (int k = 0; k < NT; k++) begin
                bus.i_tanswer_data_last[k] = ($urandom_range(0, 7) == 0);
                bus.i_packet_size_in_bytes[k*SW +: SW] = SW'($urandom_range(0, 4));
            end
            tick();
        end
        i_rst = 1'b0;
        idle_inputs();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
